prog_sequencer: RTL
===================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter PROG0_BASE, 10'd0, instruction address where program 0 begins.
REQ-002 Parameter PROG1_BASE, 10'd128, instruction address where program 1 begins.
REQ-003 Parameter PROG2_BASE, 10'd256, instruction address where program 2 begins.
REQ-004 Parameter WDOG_CYCLES, 16'd50000, RUN-cycle limit before a program is forced to end.
REQ-005 Port Clk  in  1  single clock; all state changes on posedge only.
REQ-006 Port Reset_n  in  1  asynchronous, active-low reset.
REQ-007 Port Req  in  1  bench request to run the next program; level-sensitive.
REQ-008 Port Halt  in  1  decoded halt instruction from the core; valid in RUN only.
REQ-009 Port Start  out  1  hold to the fetch unit; 1 freezes the program counter.
REQ-010 Port BranchAbs  out  1  absolute-jump strobe to the fetch unit.
REQ-011 Port Target  out  10  jump address paired with BranchAbs.
REQ-012 Port Ack  out  1  program finished; stays high until Req drops.
REQ-013 Port ProgIdx  out  2  index of the current or next program (0..2).
REQ-014 Port CycleCnt  out  16  RUN cycles of the current or last program, saturating.
REQ-015 Port Timeout  out  1  last program ended by watchdog, not by Halt.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, RUN and DONE, encoded in 2 bits.
REQ-017 IDLE: Start=1, BranchAbs=0, Ack=0; Req=1 -> LOAD on next edge.
REQ-018 LOAD lasts exactly 1 cycle: Start=0, BranchAbs=1, Target=base[ProgIdx]; CycleCnt<=0, Timeout<=0; -> RUN.
REQ-019 RUN: Start=0, BranchAbs=0; CycleCnt increments by 1 per cycle and saturates at 16'hFFFF.
REQ-020 RUN with Halt=1 -> DONE on next edge; CycleCnt holds the value it had in the Halt cycle.
REQ-021 DONE: Start=1, BranchAbs=0, Ack=1; Req=0 -> IDLE and ProgIdx advances 0->1->2->0.
REQ-022 DONE with Req still 1 SHALL remain in DONE; a new program never starts without Req first dropping.
REQ-023 Target SHALL output base[ProgIdx] in every state; ProgIdx=3 is unreachable, and Target SHALL be 0 if it occurs.
REQ-024 Halt SHALL be ignored in IDLE, LOAD and DONE.
REQ-025 Req deassertion during LOAD or RUN SHALL NOT abort the program.
REQ-026 BranchAbs and Start SHALL never be 1 in the same cycle.

Reset
REQ-027 Reset_n=0 SHALL force, asynchronously: state=IDLE, Start=1, BranchAbs=0, Target=PROG0_BASE, Ack=0, ProgIdx=0, CycleCnt=0, Timeout=0.
REQ-028 Reset in any state, including mid-RUN, SHALL discard the program; after release, the next Req runs program 0.

Configuration
REQ-029 Macro PROG_SEQ_WATCHDOG_EN: when defined, RUN with CycleCnt==WDOG_CYCLES-1 and Halt=0 -> DONE with Timeout<=1.
REQ-030 With PROG_SEQ_WATCHDOG_EN defined and Halt=1 in the same cycle as the limit, Halt wins and Timeout stays 0.
REQ-031 Without PROG_SEQ_WATCHDOG_EN, no watchdog logic exists; RUN exits only on Halt and Timeout is tied to 0.

Verification
REQ-032 Reset, then Req=1 -> one cycle later BranchAbs=1 with Target=0 and Start=0 for exactly 1 cycle; RUN follows.
REQ-033 In RUN, Halt=1 after 20 RUN cycles -> Ack=1, Start=1, CycleCnt=20; Req=0 -> IDLE and ProgIdx=1.
REQ-034 Three full Req/Halt/Req-drop cycles -> Target sequence 0, 128, 256, then ProgIdx wraps to 0.
REQ-035 Watchdog test, macro defined, WDOG_CYCLES=100, no Halt -> DONE after 100 RUN cycles, Timeout=1, CycleCnt=99; Halt at the limit cycle -> Timeout=0.
REQ-036 Reset_n pulsed low mid-RUN of program 1 -> immediate Start=1, ProgIdx=0, CycleCnt=0, with no clock edge needed.
REQ-037 Req held high through DONE for 10 cycles -> Ack stays 1, no second LOAD; BranchAbs&&Start never 1 (assertion on all tests).

Source files
------------

// File: rtl/prog_sequencer.sv
// ---------------------------------------------------------------------------
// prog_sequencer
//
// Purpose:
//   Launches up to three fixed programs on a simple core, one after another.
//   A level-sensitive request from the bench loads the next program's base
//   address into the fetch unit with an absolute-jump strobe. The sequencer
//   then counts RUN cycles until the core decodes a halt instruction. It
//   raises Ack and keeps it high until the request drops. Only then does it
//   advance to the next program, in the order 0 -> 1 -> 2 -> 0.
//
// Optional feature:
//   PROG_SEQ_WATCHDOG_EN
//     When defined, a program still running at WDOG_CYCLES RUN cycles is
//     forced to finish and Timeout is raised.
//     When undefined, RUN ends only on Halt and Timeout is tied to 0.
//
// Ports:
//   Clk        in   1   single clock, rising edge
//   Reset_n    in   1   asynchronous active-low reset
//   Req        in   1   run-next-program request (level)
//   Halt       in   1   decoded halt from the core, used only in RUN
//   Start      out  1   fetch hold; 1 freezes the program counter
//   BranchAbs  out  1   absolute-jump strobe to the fetch unit
//   Target     out  10  jump address, base of program ProgIdx
//   Ack        out  1   program finished; held until Req drops
//   ProgIdx    out  2   current or next program index (0..2)
//   CycleCnt   out  16  RUN cycles of the current or last program, saturating
//   Timeout    out  1   last program was ended by the watchdog
// ---------------------------------------------------------------------------
module prog_sequencer #(
  parameter logic [9:0]  PROG0_BASE  = 10'd0,
  parameter logic [9:0]  PROG1_BASE  = 10'd128,
  parameter logic [9:0]  PROG2_BASE  = 10'd256,
  parameter logic [15:0] WDOG_CYCLES = 16'd50000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Req,
  input  logic        Halt,
  output logic        Start,
  output logic        BranchAbs,
  output logic [9:0]  Target,
  output logic        Ack,
  output logic [1:0]  ProgIdx,
  output logic [15:0] CycleCnt,
  output logic        Timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seqState_e;

  seqState_e   state_q, state_d;
  logic [1:0]  progIdx_q, progIdx_d;
  logic [15:0] cycleCnt_q, cycleCnt_d;

  // Saturated count: the counter stops at all-ones instead of wrapping.
  logic        cntSat;
  assign cntSat = (cycleCnt_q == 16'hFFFF);

`ifdef PROG_SEQ_WATCHDOG_EN
  logic timeout_q, timeout_d;
  logic wdogHit;

  // The limit is reached in the RUN cycle whose count equals WDOG_CYCLES-1.
  // That is the WDOG_CYCLES-th RUN cycle, because the count starts at 0.
  assign wdogHit = (cycleCnt_q == (WDOG_CYCLES - 16'd1));
`endif

  // State and datapath registers. An asynchronous reset discards any running
  // program and leaves the sequencer ready to run program 0.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      progIdx_q  <= 2'd0;
      cycleCnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      progIdx_q  <= progIdx_d;
      cycleCnt_q <= cycleCnt_d;
    end
  end

`ifdef PROG_SEQ_WATCHDOG_EN
  // Timeout flag. It is cleared when a program is loaded and set only by the
  // watchdog exit, so it describes the most recently finished program.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end
`endif

  // Next-state logic. Halt matters only in RUN. Req matters only in IDLE,
  // where it starts a program, and in DONE, where it must drop before the
  // sequencer moves to the next program. When Halt and the watchdog limit
  // occur in the same cycle, Halt takes priority.
  always_comb begin
    state_d    = state_q;
    progIdx_d  = progIdx_q;
    cycleCnt_d = cycleCnt_q;
`ifdef PROG_SEQ_WATCHDOG_EN
    timeout_d  = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (Req) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        cycleCnt_d = 16'd0;
`ifdef PROG_SEQ_WATCHDOG_EN
        timeout_d  = 1'b0;
`endif
        state_d    = RUN;
      end
      RUN: begin
        if (Halt) begin
          state_d = DONE;
`ifdef PROG_SEQ_WATCHDOG_EN
        end else if (wdogHit) begin
          state_d   = DONE;
          timeout_d = 1'b1;
`endif
        end else if (!cntSat) begin
          cycleCnt_d = cycleCnt_q + 16'd1;
        end
      end
      DONE: begin
        if (!Req) begin
          state_d   = IDLE;
          progIdx_d = (progIdx_q == 2'd2) ? 2'd0 : progIdx_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the state. Start and BranchAbs come from
  // disjoint states, so they can never be high together.
  always_comb begin
    Start     = 1'b0;
    BranchAbs = 1'b0;
    Ack       = 1'b0;
    case (state_q)
      IDLE:    Start = 1'b1;
      LOAD:    BranchAbs = 1'b1;
      RUN:     Start = 1'b0;
      DONE: begin
        Start = 1'b1;
        Ack   = 1'b1;
      end
      default: Start = 1'b1;
    endcase
  end

  // Base address lookup, driven in every state. Index 3 cannot be reached;
  // it decodes to address 0.
  always_comb begin
    Target = 10'd0;
    case (progIdx_q)
      2'd0:    Target = PROG0_BASE;
      2'd1:    Target = PROG1_BASE;
      2'd2:    Target = PROG2_BASE;
      default: Target = 10'd0;
    endcase
  end

  assign ProgIdx  = progIdx_q;
  assign CycleCnt = cycleCnt_q;

`ifdef PROG_SEQ_WATCHDOG_EN
  assign Timeout = timeout_q;
`else
  assign Timeout = 1'b0;
`endif

endmodule
